// File: rtl/metro_pkg.sv
// Shared types and default constants for the metro fare vendor.
// Holds the FSM state enum and the per-ticket fare calculation.
package metro_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        REFUND = 2'd2
    } metro_state_e;

    localparam int unsigned DEF_COIN_A_VAL        = 1;
    localparam int unsigned DEF_COIN_B_VAL        = 10;
    localparam int unsigned DEF_BASE_FARE         = 2;
    localparam int unsigned DEF_STATIONS_PER_BAND = 5;
    localparam int unsigned DEF_MAX_FARE          = 9;
    localparam int unsigned DEF_HOME_STATION      = 63;

    // Banded single-ticket fare; zero stations means no valid journey.
    function automatic int unsigned calc_fare(input int unsigned stations,
                                              input int unsigned base,
                                              input int unsigned band,
                                              input int unsigned cap);
        int unsigned f;
        if (stations == 0) begin
            return 0;
        end
        f = base + (stations - 1) / band;
        return (f > cap) ? cap : f;
    endfunction

endpackage

// File: rtl/metro_edge_det.sv
// Rising-edge detector: registered previous sample, event while input is 1
// and the previous sample was 0.
module metro_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/metro_fare_vendor.sv
// Metro ticket vending controller: coin credit, banded fare, ticket/change pulses.
// Define METRO_IDLE_TIMEOUT_EN to auto-refund credit left idle for TIMEOUT_CYCLES.
module metro_fare_vendor
    import metro_pkg::*;
#(
    parameter int unsigned MONEY_W           = 8,
    parameter int unsigned STATION_W         = 8,
    parameter int unsigned TKT_W             = 2,
    parameter int unsigned HOME_STATION      = DEF_HOME_STATION,
    parameter int unsigned COIN_A_VAL        = DEF_COIN_A_VAL,
    parameter int unsigned COIN_B_VAL        = DEF_COIN_B_VAL,
    parameter int unsigned BASE_FARE         = DEF_BASE_FARE,
    parameter int unsigned STATIONS_PER_BAND = DEF_STATIONS_PER_BAND,
    parameter int unsigned MAX_FARE          = DEF_MAX_FARE,
    parameter int unsigned TIMEOUT_CYCLES    = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coin_a,
    input  logic                 coin_b,
    input  logic                 yes,
    input  logic                 no,
    input  logic [TKT_W-1:0]     num_ticket,
    input  logic [STATION_W-1:0] destination,
    output logic [MONEY_W-1:0]   credit,
    output logic [MONEY_W-1:0]   fare_due,
    output logic                 change_pulse,
    output logic                 ticket_pulse,
    output logic                 coin_reject,
    output logic                 fare_err,
    output logic                 busy,
    output metro_state_e         state_dbg
);
    localparam int unsigned PROD_W = MONEY_W + TKT_W;
    localparam logic [STATION_W-1:0] HOME = STATION_W'(HOME_STATION);
    localparam logic [MONEY_W-1:0] MONEY_MAX = '1;

    logic coin_a_ev, coin_b_ev, yes_ev, no_ev, refund_req;

    metro_edge_det u_edge_a   (.clk(clk), .rst(rst), .sig_i(coin_a), .rise_o(coin_a_ev));
    metro_edge_det u_edge_b   (.clk(clk), .rst(rst), .sig_i(coin_b), .rise_o(coin_b_ev));
    metro_edge_det u_edge_yes (.clk(clk), .rst(rst), .sig_i(yes),    .rise_o(yes_ev));
    metro_edge_det u_edge_no  (.clk(clk), .rst(rst), .sig_i(no),     .rise_o(no_ev));

    metro_state_e       state_q, state_d;
    logic [MONEY_W-1:0] credit_q, credit_d;
    logic [MONEY_W-1:0] change_left_q, change_left_d;
    logic [TKT_W:0]     tickets_left_q, tickets_left_d;
    logic [MONEY_W-1:0] fare_due_q, fare_due_d;
    logic               sel_valid_q, sel_valid_d;
    logic               change_pulse_q, change_pulse_d;
    logic               ticket_pulse_q, ticket_pulse_d;
    logic               coin_reject_q, coin_reject_d;
    logic               fare_err_q, fare_err_d;

    logic [STATION_W-1:0] stations;
    logic [MONEY_W-1:0]   fare_one;
    logic [TKT_W:0]       tkt_count;
    logic [PROD_W-1:0]    fare_prod;
    logic [MONEY_W:0]     sum_a, sum_b;

    // Fare pipeline: fare_due lags the selection inputs by one cycle.
    always_comb begin
        stations    = (destination >= HOME) ? (destination - HOME) : (HOME - destination);
        fare_one    = MONEY_W'(calc_fare(int'(stations), BASE_FARE, STATIONS_PER_BAND, MAX_FARE));
        tkt_count   = {1'b0, num_ticket} + {{TKT_W{1'b0}}, 1'b1};
        fare_prod   = PROD_W'(fare_one) * PROD_W'(tkt_count);
        fare_due_d  = (|fare_prod[PROD_W-1:MONEY_W]) ? MONEY_MAX : fare_prod[MONEY_W-1:0];
        sel_valid_d = (stations != '0);
        sum_a       = {1'b0, credit_q} + (MONEY_W+1)'(COIN_A_VAL);
        sum_b       = {1'b0, credit_q} + (MONEY_W+1)'(COIN_B_VAL);
    end

`ifdef METRO_IDLE_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              timeout;

    assign timeout = (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES));

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (state_q != IDLE || credit_q == '0 || coin_a_ev || coin_b_ev || yes_ev || no_ev) begin
            idle_cnt_d = '0;
        end else if (!timeout) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign refund_req = (no_ev || timeout) && (credit_q != '0);
`else
    assign refund_req = no_ev && (credit_q != '0);
`endif

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        change_left_d  = change_left_q;
        tickets_left_d = tickets_left_q;
        change_pulse_d = 1'b0;
        ticket_pulse_d = 1'b0;
        coin_reject_d  = 1'b0;
        fare_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (refund_req) begin
                    change_left_d = credit_q;
                    credit_d      = '0;
                    coin_reject_d = coin_a_ev | coin_b_ev;
                    state_d       = REFUND;
                end else if (yes_ev && sel_valid_q && (credit_q >= fare_due_q)) begin
                    change_left_d  = credit_q - fare_due_q;
                    tickets_left_d = tkt_count;
                    credit_d       = '0;
                    coin_reject_d  = coin_a_ev | coin_b_ev;
                    state_d        = VEND;
                end else begin
                    fare_err_d = yes_ev;
                    // coin_b wins a simultaneous insertion; coin_a is returned.
                    if (coin_b_ev) begin
                        if (sum_b[MONEY_W]) coin_reject_d = 1'b1;
                        else                credit_d      = sum_b[MONEY_W-1:0];
                        if (coin_a_ev)      coin_reject_d = 1'b1;
                    end else if (coin_a_ev) begin
                        if (sum_a[MONEY_W]) coin_reject_d = 1'b1;
                        else                credit_d      = sum_a[MONEY_W-1:0];
                    end
                end
            end
            VEND, REFUND: begin
                // Each pulse is high one cycle, low the next; tickets_left is 0 in REFUND.
                coin_reject_d = coin_a_ev | coin_b_ev;
                if (!change_pulse_q && change_left_q != '0) begin
                    change_pulse_d = 1'b1;
                    change_left_d  = change_left_q - MONEY_W'(1);
                end
                if (!ticket_pulse_q && tickets_left_q != '0) begin
                    ticket_pulse_d = 1'b1;
                    tickets_left_d = tickets_left_q - (TKT_W+1)'(1);
                end
                if (change_left_q == '0 && tickets_left_q == '0 && !change_pulse_q && !ticket_pulse_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            change_left_q  <= '0;
            tickets_left_q <= '0;
            fare_due_q     <= '0;
            sel_valid_q    <= 1'b0;
            change_pulse_q <= 1'b0;
            ticket_pulse_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            fare_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_left_q  <= change_left_d;
            tickets_left_q <= tickets_left_d;
            fare_due_q     <= fare_due_d;
            sel_valid_q    <= sel_valid_d;
            change_pulse_q <= change_pulse_d;
            ticket_pulse_q <= ticket_pulse_d;
            coin_reject_q  <= coin_reject_d;
            fare_err_q     <= fare_err_d;
        end
    end

    assign credit       = credit_q;
    assign fare_due     = fare_due_q;
    assign change_pulse = change_pulse_q;
    assign ticket_pulse = ticket_pulse_q;
    assign coin_reject  = coin_reject_q;
    assign fare_err     = fare_err_q;
    assign busy         = (state_q == VEND) || (state_q == REFUND);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_metro_fare_vendor.sv
// Self-checking bench for metro_fare_vendor: directed scenarios plus randomized
// transactions checked against a plain-arithmetic fare and outcome model.
module tb_metro_fare_vendor;
    import metro_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_a = 1'b0, coin_b = 1'b0, yes = 1'b0, no = 1'b0;
    logic [1:0] num_ticket = 2'd0;
    logic [7:0] destination = 8'd63;
    logic [7:0] credit, fare_due;
    logic       change_pulse, ticket_pulse, coin_reject, fare_err, busy;
    metro_state_e state_dbg;

    int tests_run = 0;
    int tests_failed = 0;
    int n_change = 0, n_ticket = 0, n_rej = 0, n_ferr = 0, n_wide = 0;
    logic prev_c = 1'b0, prev_t = 1'b0;

    always #5 clk = ~clk;

    metro_fare_vendor dut (
        .clk(clk), .rst(rst), .coin_a(coin_a), .coin_b(coin_b), .yes(yes), .no(no),
        .num_ticket(num_ticket), .destination(destination), .credit(credit),
        .fare_due(fare_due), .change_pulse(change_pulse), .ticket_pulse(ticket_pulse),
        .coin_reject(coin_reject), .fare_err(fare_err), .busy(busy), .state_dbg(state_dbg)
    );

    // Cumulative pulse counters; scenarios take deltas.
    always @(negedge clk) begin
        if (change_pulse) n_change++;
        if (ticket_pulse) n_ticket++;
        if (coin_reject)  n_rej++;
        if (fare_err)     n_ferr++;
        if ((change_pulse && prev_c) || (ticket_pulse && prev_t)) n_wide++;
        prev_c = change_pulse;
        prev_t = ticket_pulse;
    end

    function automatic int model_fare(input int dest, input int nt);
        int st, f, tot;
        st = (dest > 63) ? dest - 63 : 63 - dest;
        if (st == 0) return 0;
        f = 2 + (st - 1) / 5;
        if (f > 9) f = 9;
        tot = f * (nt + 1);
        return (tot > 255) ? 255 : tot;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise the selected inputs for one cycle, then drop them for one cycle.
    task automatic drive_edge(input logic a, input logic b, input logic y, input logic n);
        coin_a = a; coin_b = b; yes = y; no = n;
        tick();
        coin_a = 1'b0; coin_b = 1'b0; yes = 1'b0; no = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_idle: busy=%0b after %0d cycles, required 0", name, busy, budget);
        end
    endtask

    task automatic set_sel(input int dest, input int nt);
        destination = 8'(dest);
        num_ticket  = 2'(nt);
        tick();
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests_run++;
        if ({credit, fare_due, change_pulse, ticket_pulse, coin_reject, fare_err, busy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: credit=%0d fare_due=%0d pulses=%b%b%b%b busy=%b, required all 0",
                     credit, fare_due, change_pulse, ticket_pulse, coin_reject, fare_err, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_vend();
        int c0, t0, w0;
        set_sel(70, 1);
        tests_run++;
        if (fare_due !== 8'(model_fare(70, 1))) begin
            tests_failed++;
            $display("FAIL basic_fare: fare_due=%0d, required %0d", fare_due, model_fare(70, 1));
        end
        c0 = n_change; t0 = n_ticket; w0 = n_wide;
        drive_edge(0, 1, 0, 0);
        tests_run++;
        if (credit !== 8'd10) begin
            tests_failed++;
            $display("FAIL basic_credit: credit=%0d, required 10", credit);
        end
        drive_edge(0, 0, 1, 0);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_busy: busy=%0b, required 1", busy);
        end
        wait_idle(100, "basic");
        tests_run++;
        if (n_change - c0 != 4 || n_ticket - t0 != 2 || n_wide != w0 || credit !== 8'd0) begin
            tests_failed++;
            $display("FAIL basic_vend: change=%0d tickets=%0d wide=%0d credit=%0d, required 4 2 0 0",
                     n_change - c0, n_ticket - t0, n_wide - w0, credit);
        end
    endtask

    task automatic test_invalid_dest();
        int c0, t0, f0;
        set_sel(63, 0);
        tests_run++;
        if (fare_due !== 8'd0) begin
            tests_failed++;
            $display("FAIL invalid_fare: fare_due=%0d, required 0", fare_due);
        end
        drive_edge(0, 1, 0, 0);
        c0 = n_change; t0 = n_ticket; f0 = n_ferr;
        drive_edge(0, 0, 1, 0);
        tests_run++;
        if (n_ferr - f0 != 1 || credit !== 8'd10 || busy !== 1'b0 || n_change != c0 || n_ticket != t0) begin
            tests_failed++;
            $display("FAIL invalid_yes: fare_err=%0d credit=%0d busy=%0b pulses=%0d, required 1 10 0 0",
                     n_ferr - f0, credit, busy, (n_change - c0) + (n_ticket - t0));
        end
        drive_edge(0, 0, 0, 1);
        wait_idle(100, "invalid_cleanup");
    endtask

    task automatic test_refund();
        int c0, t0;
        drive_edge(0, 1, 0, 0);
        drive_edge(1, 0, 0, 0);
        tests_run++;
        if (credit !== 8'd11) begin
            tests_failed++;
            $display("FAIL refund_credit: credit=%0d, required 11", credit);
        end
        c0 = n_change; t0 = n_ticket;
        drive_edge(0, 0, 0, 1);
        tests_run++;
        if (busy !== 1'b1 || credit !== 8'd0) begin
            tests_failed++;
            $display("FAIL refund_busy: busy=%0b credit=%0d, required 1 0", busy, credit);
        end
        wait_idle(100, "refund");
        tests_run++;
        if (n_change - c0 != 11 || n_ticket != t0) begin
            tests_failed++;
            $display("FAIL refund_count: change=%0d tickets=%0d, required 11 0", n_change - c0, n_ticket - t0);
        end
    endtask

    task automatic test_fare_cap();
        int c0, t0, f0;
        set_sel(0, 0);
        tests_run++;
        if (fare_due !== 8'(model_fare(0, 0))) begin
            tests_failed++;
            $display("FAIL cap_fare: fare_due=%0d, required %0d", fare_due, model_fare(0, 0));
        end
        for (int i = 0; i < 5; i++) drive_edge(1, 0, 0, 0);
        f0 = n_ferr;
        drive_edge(0, 0, 1, 0);
        tests_run++;
        if (n_ferr - f0 != 1 || credit !== 8'd5 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL cap_short: fare_err=%0d credit=%0d busy=%0b, required 1 5 0", n_ferr - f0, credit, busy);
        end
        drive_edge(0, 1, 0, 0);
        c0 = n_change; t0 = n_ticket;
        drive_edge(0, 0, 1, 0);
        wait_idle(100, "cap");
        tests_run++;
        if (n_change - c0 != 6 || n_ticket - t0 != 1) begin
            tests_failed++;
            $display("FAIL cap_vend: change=%0d tickets=%0d, required 6 1", n_change - c0, n_ticket - t0);
        end
    endtask

    task automatic test_overflow();
        int r0, c0;
        for (int i = 0; i < 25; i++) drive_edge(0, 1, 0, 0);
        r0 = n_rej;
        drive_edge(0, 1, 0, 0);
        tests_run++;
        if (credit !== 8'd250 || n_rej - r0 != 1) begin
            tests_failed++;
            $display("FAIL overflow_b: credit=%0d reject=%0d, required 250 1", credit, n_rej - r0);
        end
        for (int i = 0; i < 5; i++) drive_edge(1, 0, 0, 0);
        r0 = n_rej;
        drive_edge(1, 0, 0, 0);
        tests_run++;
        if (credit !== 8'd255 || n_rej - r0 != 1) begin
            tests_failed++;
            $display("FAIL overflow_a: credit=%0d reject=%0d, required 255 1", credit, n_rej - r0);
        end
        c0 = n_change;
        drive_edge(0, 0, 0, 1);
        wait_idle(600, "overflow");
        tests_run++;
        if (n_change - c0 != 255) begin
            tests_failed++;
            $display("FAIL overflow_refund: change=%0d, required 255", n_change - c0);
        end
    endtask

    task automatic test_simul_coins();
        int r0;
        r0 = n_rej;
        drive_edge(1, 1, 0, 0);
        tests_run++;
        if (credit !== 8'd10 || n_rej - r0 != 1) begin
            tests_failed++;
            $display("FAIL simul_coins: credit=%0d reject=%0d, required 10 1", credit, n_rej - r0);
        end
        drive_edge(0, 0, 0, 1);
        wait_idle(100, "simul");
    endtask

    task automatic test_coin_during_vend();
        int r0, c0, t0;
        set_sel(70, 0);
        drive_edge(0, 1, 0, 0);
        c0 = n_change; t0 = n_ticket;
        drive_edge(0, 0, 1, 0);
        r0 = n_rej;
        drive_edge(1, 0, 0, 0);
        tests_run++;
        if (n_rej - r0 != 1 || credit !== 8'd0) begin
            tests_failed++;
            $display("FAIL vend_coin: reject=%0d credit=%0d, required 1 0", n_rej - r0, credit);
        end
        wait_idle(100, "vend_coin");
        tests_run++;
        if (n_change - c0 != 7 || n_ticket - t0 != 1 || credit !== 8'd0) begin
            tests_failed++;
            $display("FAIL vend_coin_out: change=%0d tickets=%0d credit=%0d, required 7 1 0",
                     n_change - c0, n_ticket - t0, credit);
        end
    endtask

    task automatic test_yes_no();
        int c0, t0, f0;
        set_sel(70, 0);
        for (int i = 0; i < 8; i++) drive_edge(1, 0, 0, 0);
        c0 = n_change; t0 = n_ticket; f0 = n_ferr;
        drive_edge(0, 0, 1, 1);
        wait_idle(100, "yes_no");
        tests_run++;
        if (n_change - c0 != 8 || n_ticket != t0 || n_ferr != f0) begin
            tests_failed++;
            $display("FAIL yes_no: change=%0d tickets=%0d fare_err=%0d, required 8 0 0",
                     n_change - c0, n_ticket - t0, n_ferr - f0);
        end
    endtask

    task automatic test_reset_mid_vend();
        int c0, t0;
        set_sel(70, 3);
        drive_edge(0, 1, 0, 0);
        drive_edge(0, 1, 0, 0);
        drive_edge(0, 0, 1, 0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({credit, fare_due, change_pulse, ticket_pulse, coin_reject, fare_err, busy} !== '0) begin
            tests_failed++;
            $display("FAIL midvend_reset: credit=%0d fare_due=%0d pulses=%b%b%b%b busy=%b, required all 0",
                     credit, fare_due, change_pulse, ticket_pulse, coin_reject, fare_err, busy);
        end
        #2;
        rst = 1'b0;
        c0 = n_change; t0 = n_ticket;
        for (int i = 0; i < 10; i++) tick();
        tests_run++;
        if (n_change != c0 || n_ticket != t0 || busy !== 1'b0 || credit !== 8'd0) begin
            tests_failed++;
            $display("FAIL midvend_after: pulses=%0d busy=%0b credit=%0d, required 0 0 0",
                     (n_change - c0) + (n_ticket - t0), busy, credit);
        end
    endtask

    task automatic test_random();
        int dest, nt, na, nb, cred, fare, c0, t0, f0;
        bit do_yes;
        for (int it = 0; it < 20; it++) begin
            dest = ($urandom_range(0, 7) == 0) ? 63 : $urandom_range(0, 127);
            nt   = $urandom_range(0, 3);
            na   = $urandom_range(0, 6);
            nb   = $urandom_range(0, 5);
            do_yes = ($urandom_range(0, 3) != 0);
            set_sel(dest, nt);
            fare = model_fare(dest, nt);
            tests_run++;
            if (fare_due !== 8'(fare)) begin
                tests_failed++;
                $display("FAIL rand_fare[%0d]: dest=%0d nt=%0d fare_due=%0d, required %0d", it, dest, nt, fare_due, fare);
            end
            for (int i = 0; i < na; i++) drive_edge(1, 0, 0, 0);
            for (int i = 0; i < nb; i++) drive_edge(0, 1, 0, 0);
            cred = na + 10 * nb;
            c0 = n_change; t0 = n_ticket; f0 = n_ferr;
            if (do_yes && dest != 63 && cred >= fare) begin
                drive_edge(0, 0, 1, 0);
                wait_idle(200, "rand_vend");
                tests_run++;
                if (n_change - c0 != cred - fare || n_ticket - t0 != nt + 1 || credit !== 8'd0) begin
                    tests_failed++;
                    $display("FAIL rand_vend[%0d]: change=%0d tickets=%0d credit=%0d, required %0d %0d 0",
                             it, n_change - c0, n_ticket - t0, credit, cred - fare, nt + 1);
                end
            end else begin
                if (do_yes) begin
                    drive_edge(0, 0, 1, 0);
                    tests_run++;
                    if (n_ferr - f0 != 1 || credit !== 8'(cred)) begin
                        tests_failed++;
                        $display("FAIL rand_refused[%0d]: fare_err=%0d credit=%0d, required 1 %0d",
                                 it, n_ferr - f0, credit, cred);
                    end
                end
                drive_edge(0, 0, 0, 1);
                wait_idle(200, "rand_refund");
                tests_run++;
                if (n_change - c0 != cred || n_ticket != t0 || credit !== 8'd0) begin
                    tests_failed++;
                    $display("FAIL rand_refund[%0d]: change=%0d tickets=%0d credit=%0d, required %0d 0 0",
                             it, n_change - c0, n_ticket - t0, credit, cred);
                end
            end
        end
    endtask

`ifdef METRO_IDLE_TIMEOUT_EN
    task automatic test_idle_timeout();
        int c0;
        c0 = n_change;
        for (int i = 0; i < 3; i++) drive_edge(1, 0, 0, 0);
        for (int i = 0; i < 1100 && n_change - c0 < 3; i++) tick();
        wait_idle(100, "timeout");
        tests_run++;
        if (n_change - c0 != 3 || credit !== 8'd0) begin
            tests_failed++;
            $display("FAIL idle_timeout: change=%0d credit=%0d, required 3 0", n_change - c0, credit);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_vend();
        test_invalid_dest();
        test_refund();
        test_fare_cap();
        test_overflow();
        test_simul_coins();
        test_coin_during_vend();
        test_yes_no();
        test_reset_mid_vend();
        test_random();
`ifdef METRO_IDLE_TIMEOUT_EN
        test_idle_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/metro_fare_vendor.md
Name: metro_fare_vendor

Overview:
Parametrised next-generation metro ticket vending controller. It accepts coins on two edge-detected coin inputs and computes a banded, capped fare from the home station to the selected destination. On confirm it dispenses tickets and change as discrete one-cycle pulses; on cancel it refunds the full credit. It sits between the front-panel inputs and the coin and ticket dispenser drivers.

Parameters:
MONEY_W, 8, width of credit, fare and change counters
STATION_W, 8, width of station codes
TKT_W, 2, width of ticket-count select; ticket count = num_ticket+1
HOME_STATION, 63, station code of this machine
COIN_A_VAL, 1, value of coin_a insertion
COIN_B_VAL, 10, value of coin_b insertion
BASE_FARE, 2, fare for 1..STATIONS_PER_BAND stations
STATIONS_PER_BAND, 5, stations per fare increment
MAX_FARE, 9, per-ticket fare cap
TIMEOUT_CYCLES, 1000, idle cycles before auto-refund (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
coin_a  in  1  coin A sensor level
coin_b  in  1  coin B sensor level
yes  in  1  confirm button level
no  in  1  cancel button level
num_ticket  in  TKT_W  tickets requested minus one
destination  in  STATION_W  destination station code
credit  out  MONEY_W  current inserted credit
fare_due  out  MONEY_W  total fare for the current selection
change_pulse  out  1  one pulse per unit of change or refund
ticket_pulse  out  1  one pulse per ticket issued
coin_reject  out  1  one-cycle pulse: inserted coin returned, not credited
fare_err  out  1  one-cycle pulse: confirm refused
busy  out  1  high in VEND or REFUND

Behaviour:
- Reset: all outputs and counters 0, state IDLE, edge-history registers 0. Reset mid-VEND or mid-REFUND abandons the remaining pulses.
- Edge detect: an event fires in the cycle where the input is 1 and the registered previous sample is 0. The event takes effect at that clock edge.
- fare_due is registered and updated every cycle. stations = |destination - HOME_STATION|.
  - stations = 0: fare_due = 0, selection invalid.
  - Otherwise fare = min(BASE_FARE + (stations-1)/STATIONS_PER_BAND, MAX_FARE), and fare_due = fare*(num_ticket+1).
  - Intermediate products use MONEY_W+TKT_W bits; fare_due saturates at 2^MONEY_W-1.
- States: IDLE, VEND, REFUND.
- IDLE, coin event: credit += coin value.
  - If the sum would exceed 2^MONEY_W-1, credit is unchanged and coin_reject pulses.
  - coin_a and coin_b events in the same cycle: coin_b is credited, coin_a is rejected.
- IDLE, no event (priority over yes): change_left <= credit, credit <= 0, go to REFUND. If credit = 0, stay in IDLE.
- IDLE, yes event:
  - If the selection is valid and credit >= fare_due: change_left <= credit - fare_due, tickets_left <= num_ticket+1, credit <= 0, go to VEND.
  - Otherwise fare_err pulses and state and credit are unchanged.
  - A coin event in the same cycle as an accepted yes is rejected (coin_reject).
- VEND: change and tickets dispense concurrently.
  - Each nonzero counter produces a pulse high for 1 cycle then low for 1 cycle, decrementing on the high cycle.
  - Return to IDLE once both counters are 0 and both pulses are low.
- REFUND: same 2-cycle pulse scheme on change_left only, then IDLE.
- VEND/REFUND: every coin event is rejected; yes and no are ignored. destination and num_ticket are sampled only at yes acceptance.

Optional Feature:
METRO_IDLE_TIMEOUT_EN
- Defined: an idle counter runs in IDLE while credit > 0 and clears on any coin, yes or no event. Reaching TIMEOUT_CYCLES behaves exactly as a no event (auto-refund).
- Undefined: no counter is built and credit is held indefinitely.

Decomposition:
- Package metro_pkg: state enum (IDLE, VEND, REFUND), default coin values, base fare, band size, fare cap, home station constant, and a pure fare-computation function.
- One sub-module, metro_edge_det: registered previous-sample plus rising-edge output, instantiated four times.

Test Plan:
- Destination 70, num_ticket 1, coin_b once, yes -> fare_due 6; 4 change_pulse and 2 ticket_pulse, each high 1 cycle; back to IDLE with credit 0.
- Destination 63, credit 10, yes -> fare_err pulse; credit stays 10; no pulses.
- Credit 11 (coin_b + coin_a), no -> exactly 11 change_pulse, busy high throughout, then IDLE.
- Destination 0, num_ticket 0 (63 stations, cap) -> fare_due 9; credit 5 plus yes -> fare_err; add 10 then yes -> 6 change pulses, 1 ticket.
- Credit 250, coin_b -> coin_reject, credit 250. Simultaneous coin_a+coin_b at credit 0 -> credit 10, coin_reject. Coin during VEND -> coin_reject.
- yes+no same cycle with credit 8 -> refund 8; rst asserted mid-VEND -> all outputs 0 immediately. With METRO_IDLE_TIMEOUT_EN, credit 3 left idle for TIMEOUT_CYCLES -> 3 change pulses.
